// File: rtl/haze_window_3x3_if.sv
// Pixel-stream in / 3x3-window out bundle between the pixel source and haze_window_3x3.
// Master drives pixels and observes windows; slave is the window former.
interface haze_window_3x3_if #(
   parameter int PIXEL_W = 24
);
   logic [PIXEL_W-1:0]   input_pixel;
   logic                 input_is_valid;
   logic [9*PIXEL_W-1:0] window;
   logic                 output_is_valid;
   logic                 frame_done;
   logic                 overflow_err;

   modport master (
      output input_pixel, input_is_valid,
      input  window, output_is_valid, frame_done, overflow_err
   );
   modport slave (
      input  input_pixel, input_is_valid,
      output window, output_is_valid, frame_done, overflow_err
   );
endinterface

// File: rtl/haze_window_3x3.sv
// Raster RGB stream to one 3x3 neighbourhood per pixel, border pixels replicated.
// Define ZERO_PAD_EN to force out-of-image neighbours to zero instead of replicating.
module haze_window_3x3 #(
   parameter int IMG_WIDTH  = 512,
   parameter int IMG_HEIGHT = 512,
   parameter int PIXEL_W    = 24
) (
   input  logic             clk,
   input  logic             rst,
   haze_window_3x3_if.slave bus
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
`ifdef ZERO_PAD_EN
   localparam bit ZERO_PAD = 1'b1;
`else
   localparam bit ZERO_PAD = 1'b0;
`endif

   typedef enum logic [1:0] {FILL = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_e;
   // One image column of the window: [0]=upper row, [1]=centre row, [2]=lower row.
   typedef logic [2:0][PIXEL_W-1:0] column_t;

   state_e               state_q, state_d;
   logic [CW-1:0]        col_q, col_d;
   logic [RW-1:0]        row_q, row_d;
   logic                 tail_q, tail_d;
   column_t              col_a_q, col_a_d, col_b_q, col_b_d;
   logic [9*PIXEL_W-1:0] window_q, window_d;
   logic                 valid_q, valid_d, frame_done_q, frame_done_d, overflow_q, overflow_d;
   logic [PIXEL_W-1:0]   lb0_mem [IMG_WIDTH];
   logic [PIXEL_W-1:0]   lb1_mem [IMG_WIDTH];
   logic                 step_s, emit_s, top_s, bot_s;
   column_t              col_n_s, left_s, centre_s, right_s;

   function automatic column_t fix_rows(input column_t v, input logic top, input logic bot);
      column_t r;
      r = v;
      if (top) r[0] = ZERO_PAD ? '0 : v[1];
      else     r[0] = v[0];
      if (bot) r[2] = ZERO_PAD ? '0 : v[1];
      else     r[2] = v[2];
      return r;
   endfunction

   // Sequencing: decides acceptance, emission and the next counter/state values.
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      tail_d       = tail_q;
      step_s       = 1'b0;
      emit_s       = 1'b0;
      frame_done_d = 1'b0;
      overflow_d   = overflow_q;
      case (state_q)
         FILL, RUN: begin
            if (bus.input_is_valid) begin
               step_s = 1'b1;
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  row_d = row_q + RW'(1);
               end else begin
                  col_d = col_q + CW'(1);
               end
               if (state_q == RUN) begin
                  emit_s = 1'b1;
                  if (col_q == COL_LAST && row_q == ROW_LAST) begin
                     state_d = FLUSH;
                     col_d   = '0;
                     row_d   = '0;
                  end else begin
                     state_d = RUN;
                  end
               end else if (row_q == RW'(1) && col_q == CW'(1)) begin
                  emit_s  = 1'b1;
                  state_d = RUN;
               end else begin
                  state_d = FILL;
               end
            end else begin
               step_s = 1'b0;
            end
         end
         FLUSH: begin
            step_s     = 1'b1;
            emit_s     = 1'b1;
            overflow_d = overflow_q | bus.input_is_valid;
            // A full row of virtual pixels plus one extra tail step reaches (H-1,W-1).
            if (tail_q) begin
               state_d      = FILL;
               col_d        = '0;
               row_d        = '0;
               tail_d       = 1'b0;
               frame_done_d = 1'b1;
            end else if (col_q == COL_LAST) begin
               col_d  = '0;
               tail_d = 1'b1;
            end else begin
               col_d = col_q + CW'(1);
            end
         end
         default: begin
            state_d = FILL;
            col_d   = '0;
            row_d   = '0;
            tail_d  = 1'b0;
         end
      endcase
   end

   // Window assembly: newest column plus two held columns, borders muxed from counter compares.
   always_comb begin
      col_n_s    = '0;
      col_n_s[0] = lb0_mem[col_q];
      col_n_s[1] = lb1_mem[col_q];
      if (state_q == FLUSH) col_n_s[2] = '0;
      else                  col_n_s[2] = bus.input_pixel;
      // Centre column is col_b; its row is one behind the write row, two behind at column 0.
      if (state_q == FLUSH) begin
         top_s = 1'b0;
         bot_s = !(col_q == '0 && !tail_q);
      end else begin
         top_s = (col_q != '0) ? (row_q == RW'(1)) : (row_q == RW'(2));
         bot_s = 1'b0;
      end
      centre_s = fix_rows(col_b_q, top_s, bot_s);
      if (col_q == CW'(1)) left_s = ZERO_PAD ? '0 : centre_s;
      else                 left_s = fix_rows(col_a_q, top_s, bot_s);
      if (col_q == '0) right_s = ZERO_PAD ? '0 : centre_s;
      else             right_s = fix_rows(col_n_s, top_s, bot_s);
      window_d = window_q;
      if (emit_s) begin
         for (int i = 0; i < 3; i++) begin
            window_d[PIXEL_W*(3*i+0) +: PIXEL_W] = left_s[i];
            window_d[PIXEL_W*(3*i+1) +: PIXEL_W] = centre_s[i];
            window_d[PIXEL_W*(3*i+2) +: PIXEL_W] = right_s[i];
         end
      end else begin
         window_d = window_q;
      end
      col_a_d = step_s ? col_b_q : col_a_q;
      col_b_d = step_s ? col_n_s : col_b_q;
      valid_d = emit_s;
   end

   // State, counters, column registers and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= FILL;
         col_q        <= '0;
         row_q        <= '0;
         tail_q       <= 1'b0;
         col_a_q      <= '0;
         col_b_q      <= '0;
         window_q     <= '0;
         valid_q      <= 1'b0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         tail_q       <= tail_d;
         col_a_q      <= col_a_d;
         col_b_q      <= col_b_d;
         window_q     <= window_d;
         valid_q      <= valid_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
      end
   end

   // Line buffers: the older row takes the younger row's entry, the younger row takes the new pixel.
   always_ff @(posedge clk) begin
      if (rst && step_s) begin
         lb0_mem[col_q] <= col_n_s[1];
         lb1_mem[col_q] <= col_n_s[2];
      end
   end

   assign bus.window          = window_q;
   assign bus.output_is_valid = valid_q;
   assign bus.frame_done      = frame_done_q;
   assign bus.overflow_err    = overflow_q;
endmodule

// File: tb/tb_haze_window_3x3.sv
// Self-checking bench for haze_window_3x3 at W=4, H=3 against a clamp/zero-pad neighbourhood model.
module tb_haze_window_3x3;
   localparam int W = 4, H = 3, PW = 24, N = W * H;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   haze_window_3x3_if #(.PIXEL_W(PW)) bus();
   haze_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_W(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_tests = 0, n_fail = 0;
   logic [PW-1:0] img [H][W];
   logic [9*PW-1:0] got_q[$];
   bit got_fd_q[$];
   int gap_out, stray_fd, first_out_k, flush_outs;

   function automatic logic [PW-1:0] px(input int r, input int c);
`ifdef ZERO_PAD_EN
      if (r < 0 || r >= H || c < 0 || c >= W) return '0;
`else
      if (r < 0) r = 0;
      if (r > H - 1) r = H - 1;
      if (c < 0) c = 0;
      if (c > W - 1) c = W - 1;
`endif
      return img[r][c];
   endfunction

   function automatic logic [9*PW-1:0] model_win(input int r, input int c);
      logic [9*PW-1:0] w;
      w = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w[PW*(3*i+j) +: PW] = px(r - 1 + i, c - 1 + j);
      return w;
   endfunction

   function automatic logic [9*PW-1:0] pack9(input int v[9]);
      logic [9*PW-1:0] w;
      for (int i = 0; i < 9; i++) w[PW*i +: PW] = PW'(v[i]);
      return w;
   endfunction

   task automatic fill_k();
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = PW'(r * W + c);
   endtask

   task automatic fill_rand();
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = PW'($urandom);
   endtask

   task automatic tick(output bit seen);
      @(posedge clk); #1;
      seen = bus.output_is_valid;
      if (seen) begin
         got_q.push_back(bus.window);
         got_fd_q.push_back(bus.frame_done);
      end else if (bus.frame_done) begin
         stray_fd++;
      end
   endtask

   // gap_mode: 0 continuous, 1 pattern 1,0,0, 2 random gaps; ovf drives pixel 99 early in FLUSH.
   task automatic run_frame(input int gap_mode, input bit ovf);
      bit seen;
      int idle;
      got_q.delete(); got_fd_q.delete();
      gap_out = 0; stray_fd = 0; first_out_k = -1; flush_outs = 0;
      for (int k = 0; k < N; k++) begin
         bus.input_is_valid = 1'b1;
         bus.input_pixel    = img[k / W][k % W];
         tick(seen);
         if (seen && first_out_k < 0) first_out_k = k;
         idle = (k == N - 1) ? 0 : (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
         for (int g = 0; g < idle; g++) begin
            bus.input_is_valid = 1'b0;
            bus.input_pixel    = PW'($urandom);
            tick(seen);
            if (seen) gap_out++;
         end
      end
      for (int j = 0; j < 3 * W; j++) begin
         bus.input_is_valid = ovf && (j < 2);
         bus.input_pixel    = ovf ? PW'(99) : PW'($urandom);
         tick(seen);
         if (seen && j <= W) flush_outs++;
      end
      bus.input_is_valid = 1'b0;
   endtask

   task automatic test_reset();
      bit seen;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.input_is_valid = 1'($urandom);
         bus.input_pixel    = PW'($urandom);
         tick(seen);
         n_tests++;
         if (bus.window !== '0 || bus.output_is_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.overflow_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cycle%0d got win=%h v=%b fd=%b ov=%b required all zero", i, bus.window, bus.output_is_valid, bus.frame_done, bus.overflow_err);
         end
      end
      bus.input_is_valid = 1'b0;
      rst = 1'b1;
   endtask

   task automatic test_continuous();
      fill_k();
      run_frame(0, 1'b0);
      n_tests++;
      if (got_q.size() != N) begin n_fail++; $display("FAIL cont_count got=%0d required=%0d", got_q.size(), N); end
      n_tests++;
      if (first_out_k != W + 1) begin n_fail++; $display("FAIL cont_first_out got k=%0d required k=%0d", first_out_k, W + 1); end
      n_tests++;
      if (flush_outs != W + 1) begin n_fail++; $display("FAIL cont_flush_b2b got=%0d required=%0d", flush_outs, W + 1); end
      n_tests++;
      if (stray_fd != 0 || bus.overflow_err !== 1'b0) begin n_fail++; $display("FAIL cont_flags stray_fd=%0d ov=%b required 0/0", stray_fd, bus.overflow_err); end
      for (int i = 0; i < N && i < got_q.size(); i++) begin
         n_tests++;
         if (got_q[i] !== model_win(i / W, i % W) || got_fd_q[i] !== (i == N - 1)) begin
            n_fail++;
            $display("FAIL cont_win%0d got=%h fd=%b required=%h fd=%b", i, got_q[i], got_fd_q[i], model_win(i / W, i % W), (i == N - 1));
         end
      end
   endtask

   task automatic test_edges();
      int e[9];
      int idx;
      for (int t = 0; t < 3; t++) begin
`ifdef ZERO_PAD_EN
         if (t == 0)      begin idx = 0;  e = '{0, 0, 0, 0, 0, 1, 0, 4, 5}; end
         else             begin idx = 11; e = '{6, 7, 0, 10, 11, 0, 0, 0, 0}; end
`else
         if (t == 0)      begin idx = 7;  e = '{2, 3, 3, 6, 7, 7, 10, 11, 11}; end
         else if (t == 1) begin idx = 11; e = '{6, 7, 7, 10, 11, 11, 10, 11, 11}; end
         else             begin idx = 8;  e = '{4, 4, 5, 8, 8, 9, 8, 8, 9}; end
`endif
         if (idx < got_q.size()) begin
            n_tests++;
            if (got_q[idx] !== pack9(e)) begin
               n_fail++;
               $display("FAIL edge_win%0d got=%h required=%h", idx, got_q[idx], pack9(e));
            end
         end else begin
            n_tests++; n_fail++;
            $display("FAIL edge_win%0d missing, got %0d windows", idx, got_q.size());
         end
      end
   endtask

   task automatic test_gaps(input int mode);
      if (mode == 1) fill_k(); else fill_rand();
      run_frame(mode, 1'b0);
      n_tests++;
      if (got_q.size() != N || gap_out != 0 || stray_fd != 0) begin
         n_fail++;
         $display("FAIL gaps%0d_count got=%0d gap_out=%0d stray_fd=%0d required=%0d/0/0", mode, got_q.size(), gap_out, stray_fd, N);
      end
      for (int i = 0; i < N && i < got_q.size(); i++) begin
         n_tests++;
         if (got_q[i] !== model_win(i / W, i % W) || got_fd_q[i] !== (i == N - 1)) begin
            n_fail++;
            $display("FAIL gaps%0d_win%0d got=%h required=%h", mode, i, got_q[i], model_win(i / W, i % W));
         end
      end
   endtask

   task automatic test_mid_reset();
      bit seen;
      fill_rand();
      for (int k = 0; k < 7; k++) begin
         bus.input_is_valid = 1'b1;
         bus.input_pixel    = img[k / W][k % W];
         tick(seen);
      end
      rst = 1'b0;
      bus.input_pixel = PW'($urandom);
      tick(seen);
      n_tests++;
      if (bus.output_is_valid !== 1'b0 || bus.window !== '0) begin
         n_fail++;
         $display("FAIL midrst_clear got v=%b win=%h required 0", bus.output_is_valid, bus.window);
      end
      rst = 1'b1;
      bus.input_is_valid = 1'b0;
      fill_k();
      run_frame(0, 1'b0);
      n_tests++;
      if (got_q.size() != N) begin n_fail++; $display("FAIL midrst_count got=%0d required=%0d", got_q.size(), N); end
      for (int i = 0; i < N && i < got_q.size(); i++) begin
         n_tests++;
         if (got_q[i] !== model_win(i / W, i % W)) begin
            n_fail++;
            $display("FAIL midrst_win%0d got=%h required=%h", i, got_q[i], model_win(i / W, i % W));
         end
      end
   endtask

   task automatic test_overflow();
      bit seen;
      bit hit99;
      fill_k();
      run_frame(0, 1'b1);
      hit99 = 1'b0;
      for (int i = 0; i < got_q.size(); i++)
         for (int p = 0; p < 9; p++)
            if (got_q[i][PW*p +: PW] == PW'(99)) hit99 = 1'b1;
      n_tests++;
      if (got_q.size() != N || hit99) begin n_fail++; $display("FAIL ovf_frame count=%0d saw99=%b required=%0d/0", got_q.size(), hit99, N); end
      for (int i = 0; i < N && i < got_q.size(); i++) begin
         n_tests++;
         if (got_q[i] !== model_win(i / W, i % W)) begin
            n_fail++;
            $display("FAIL ovf_win%0d got=%h required=%h", i, got_q[i], model_win(i / W, i % W));
         end
      end
      n_tests++;
      if (bus.overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b required=1", bus.overflow_err); end
      fill_rand();
      run_frame(2, 1'b0);
      n_tests++;
      if (bus.overflow_err !== 1'b1 || got_q.size() != N) begin
         n_fail++;
         $display("FAIL ovf_sticky got ov=%b count=%0d required 1/%0d", bus.overflow_err, got_q.size(), N);
      end
      rst = 1'b0;
      tick(seen);
      rst = 1'b1;
      n_tests++;
      if (bus.overflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b required=0", bus.overflow_err); end
   endtask

   initial begin
      bus.input_is_valid = 1'b0;
      bus.input_pixel    = '0;
      test_reset();
      test_continuous();
      test_edges();
      test_gaps(1);
      test_gaps(2);
      test_gaps(2);
      test_mid_reset();
      test_overflow();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/haze_window_3x3.md
Name: haze_window_3x3

Overview:
- Upstream stage of the haze-removal pixel pipeline.
- Accepts the raster-order 24-bit RGB stream {R,G,B}, one pixel per valid cycle, bottom-to-top BMP row order treated as plain raster.
- Emits one 3x3 RGB neighbourhood per input pixel for the downstream dark-channel/minimum-filter stage.
- Uses two line buffers and a 3x3 register array. Border pixels are replicated. Internal flush drains the last row.

Parameters:
- IMG_WIDTH, 512, pixels per row (>=4, divisible by 4)
- IMG_HEIGHT, 512, rows per frame (>=3)
- PIXEL_W, 24, bits per pixel ({R[23:16],G[15:8],B[7:0]})

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (rst==0 resets on clk edge)
- input_pixel  in  PIXEL_W  raster pixel
- input_is_valid  in  1  pixel accepted on every clk edge where high and state != FLUSH
- window  out  9*PIXEL_W  window[PIXEL_W*(3*i+j) +: PIXEL_W] = pixel(r-1+i, c-1+j), i,j in 0..2
- output_is_valid  out  1  window valid this cycle, one-cycle pulse per window
- frame_done  out  1  high coincident with the last window (r=H-1, c=W-1)
- overflow_err  out  1  sticky; input_is_valid seen during FLUSH

Behaviour:
- Reset (rst==0 at edge): window=0, output_is_valid=0, frame_done=0, overflow_err=0. Column, row and emit counters = 0. State = FILL. Line-buffer contents are not cleared; stale data is masked by border logic.
- Emission rule: window centred at (r,c) is emitted when raster pixel k=(r+1)*W+c+1 is accepted (fixed delay of W+1 accepted pixels). Outputs are registered, so output_is_valid is high the cycle after that accepting edge.
- States:
  - FILL: accept pixels, no output, until k=W+1 accepted → RUN. The k=W+1 acceptance itself emits (0,0).
  - RUN: each accepted pixel emits one window. After the last input pixel (k=W*H-1) is accepted → FLUSH.
  - FLUSH: exactly W+1 internal cycles, one window per cycle back-to-back, independent of input_is_valid. Emits the remaining windows up to (H-1,W-1), then returns to FILL for the next frame.
- Gaps: when input_is_valid=0 in FILL/RUN, nothing shifts, output_is_valid=0, window holds its value.
- Border replicate:
  - row index <0 → row 0; row index >H-1 → row H-1.
  - col index <0 → col 0; col index >W-1 → col W-1.
  - Implemented by per-row/per-column muxing on counter compares, not extra storage.
- Exactly W*H windows per frame. Emit counter wraps to 0 after frame_done.
- input_is_valid=1 during FLUSH: pixel dropped, overflow_err set, held until reset.
- Reset mid-frame: takes priority over everything. Next accepted pixel is treated as k=0.
- Line buffers: two W-deep memories, single read + single write per accept, inferable as block RAM. Address = column counter, wraps at W-1.
- No arithmetic on pixel data; pure data movement. Counters are $clog2 of W and H wide.

Optional Feature:
- ZERO_PAD_EN
  - Defined: out-of-image neighbours are forced to 24'h000000 instead of replicated. All timing and counts are unchanged.
  - Undefined: replicate as above.

Test Plan (W=4, H=3, pixel value = raster index k, rows written [p(r-1,*)],[p(r,*)],[p(r+1,*)]):
1. Hold rst=0 for 3 cycles with random inputs → window=0, output_is_valid=0, frame_done=0, overflow_err=0 throughout.
2. Continuous frame k=0..11:
   - First output_is_valid is the cycle after k=5 is accepted.
   - Window(0,0) = [0,0,1],[0,0,1],[4,4,5].
   - 12 windows total; the last 5 come from FLUSH back-to-back.
   - frame_done only with window(2,3).
3. Edge windows from the same frame:
   - Window(1,3) = [2,3,3],[6,7,7],[10,11,11].
   - Window(2,3) = [6,7,7],[10,11,11],[10,11,11].
   - Window(2,0) = [4,4,5],[8,8,9],[8,8,9].
4. Same frame with input_is_valid pattern 1,0,0,1,… → identical 12 windows in identical order. No output in gap cycles except during FLUSH.
5. Reset after 7 pixels, then full frame → exactly 12 windows matching test 2. No stale row-0 data.
6. Assert input_is_valid with k=99 during FLUSH → 99 never appears in any window. overflow_err=1 and stays 1 across the next frame until rst=0.
7. With ZERO_PAD_EN: window(0,0) = [0,0,0],[0,0,1],[0,4,5]; window(2,3) = [6,7,0],[10,11,0],[0,0,0].
